// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
// Parametrised UART transmitter with a built-in baud divider and a small
// transmit FIFO. A producer queues characters through sendIN/dataIN and
// they leave on txOUT back-to-back, framed as
// start / DATA_BITS data (LSB first) / optional parity / STOP_BITS stop.
//
// Ports
//   clkIN         system clock, all logic on the rising edge
//   resetIN       asynchronous active-high reset, aborts any frame in flight
//   dataIN        character to queue (DATA_BITS wide)
//   sendIN        write strobe, sampled every clock
//   txOUT         serial line, idle high, driven straight from a flip-flop
//   readyOUT      FIFO not full, a push is accepted this cycle when high
//   busyOUT       frame in progress or characters still queued
//   overflowOUT   one-cycle pulse after a push was attempted while full
//   fifoCountOUT  current FIFO occupancy
module uart_tx_cfg #(
  parameter int CLK_FREQ   = 48000000,
  parameter int BAUD_RATE  = 57600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clkIN,
  input  logic                         resetIN,
  input  logic [DATA_BITS-1:0]         dataIN,
  input  logic                         sendIN,
  output logic                         txOUT,
  output logic                         readyOUT,
  output logic                         busyOUT,
  output logic                         overflowOUT,
  output logic [$clog2(FIFO_DEPTH):0]  fifoCountOUT
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int BW  = $clog2(DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  // Shared bit/stop index: 4 bits covers up to 9 data bits.
  localparam int IW  = 4;

  localparam logic [BW-1:0] DIV_LAST  = BW'(DIV - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } TxState;

  TxState               state;
  TxState               stateNext;
  logic [BW-1:0]        baudCnt;
  logic [BW-1:0]        baudNext;
  logic [IW-1:0]        bitIdx;
  logic [IW-1:0]        bitNext;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parityBit;
  logic                 txNext;
  logic                 popEn;
  logic                 shiftEn;
  logic                 pushEn;
  logic                 baudDone;

  logic [DATA_BITS-1:0] fifoMem [FIFO_DEPTH];
  logic [PW-1:0]        wrPtr;
  logic [PW-1:0]        rdPtr;
  logic [CW-1:0]        count;
  logic [DATA_BITS-1:0] headData;

  // Readiness comes from the registered count only, so a pop in the same
  // cycle never lets a full FIFO take a push.
  assign readyOUT     = (count != FULL);
  assign pushEn       = sendIN && readyOUT;
  assign busyOUT      = (state != IDLE) || (count != '0);
  assign fifoCountOUT = count;
  assign headData     = fifoMem[rdPtr];
  assign baudDone     = (baudCnt == '0);

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clkIN) begin
    if (pushEn) begin
      fifoMem[wrPtr] <= dataIN;
    end
  end

  // FIFO pointers, occupancy and the overflow pulse. A push and a pop on
  // the same edge cancel out in the count.
  always_ff @(posedge clkIN or posedge resetIN) begin
    if (resetIN) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      overflowOUT <= 1'b0;
    end else begin
      overflowOUT <= sendIN && !readyOUT;
      if (pushEn) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (popEn) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({pushEn, popEn})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Next-state logic. Every bit period counts baudCnt down from DIV-1,
  // and the counter is reloaded on each pop so frames never inherit phase
  // from the one before. The last stop clock pops straight into START when
  // more data is queued, giving gapless back-to-back frames.
  always_comb begin
    stateNext = state;
    baudNext  = baudCnt;
    bitNext   = bitIdx;
    popEn     = 1'b0;
    shiftEn   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          popEn     = 1'b1;
          stateNext = START;
          baudNext  = DIV_LAST;
          bitNext   = '0;
        end
      end
      START: begin
        if (baudDone) begin
          stateNext = DATA;
          baudNext  = DIV_LAST;
          bitNext   = '0;
        end else begin
          baudNext = baudCnt - BW'(1);
        end
      end
      DATA: begin
        if (baudDone) begin
          shiftEn  = 1'b1;
          baudNext = DIV_LAST;
          if (bitIdx == DATA_LAST) begin
            bitNext   = '0;
            stateNext = (PARITY != 0) ? PAR : STOP;
          end else begin
            bitNext = bitIdx + IW'(1);
          end
        end else begin
          baudNext = baudCnt - BW'(1);
        end
      end
      PAR: begin
        if (baudDone) begin
          stateNext = STOP;
          baudNext  = DIV_LAST;
          bitNext   = '0;
        end else begin
          baudNext = baudCnt - BW'(1);
        end
      end
      STOP: begin
        if (baudDone) begin
          if (bitIdx == STOP_LAST) begin
            if (count != '0) begin
              popEn     = 1'b1;
              stateNext = START;
              baudNext  = DIV_LAST;
              bitNext   = '0;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            bitNext  = bitIdx + IW'(1);
            baudNext = DIV_LAST;
          end
        end else begin
          baudNext = baudCnt - BW'(1);
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Line level for the current state. It is registered below, so the line
  // trails the state by one clock, which is where the two-clock push to
  // start-bit latency comes from.
  always_comb begin
    txNext = 1'b1;
    case (state)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftReg[0];
      PAR:     txNext = parityBit;
      default: txNext = 1'b1;
    endcase
  end

  // State, baud counter, shift register and the registered line. The
  // parity bit is computed once from the popped character.
  always_ff @(posedge clkIN or posedge resetIN) begin
    if (resetIN) begin
      state     <= IDLE;
      baudCnt   <= '0;
      bitIdx    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      txOUT     <= 1'b1;
    end else begin
      state   <= stateNext;
      baudCnt <= baudNext;
      bitIdx  <= bitNext;
      txOUT   <= txNext;
      if (popEn) begin
        shiftReg  <= headData;
        parityBit <= (^headData) ^ ODD_PAR;
      end else if (shiftEn) begin
        shiftReg <= shiftReg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg
// Drives three transmitters (8N1, 7O2, 7E2, all DIV=10, FIFO depth 4).
// Expected frames are built from the framing rules and queued per
// transmitter; a line monitor per transmitter decodes each frame it sees
// and compares it against the head of its queue.
module tb_uart_tx_cfg;

  localparam int DIV = 10;

  typedef struct {
    logic [15:0] bits;
    int          len;
    bit          contig;
  } FrameT;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] sendV = '0;
  logic [8:0] dataV [3];

  wire [2:0] txV;
  wire [2:0] readyV;
  wire [2:0] busyV;
  wire [2:0] ovfV;
  wire [2:0] countA;
  wire [2:0] countB;
  wire [2:0] countC;

  int checks = 0;
  int errors = 0;

  FrameT expQ0[$];
  FrameT expQ1[$];
  FrameT expQ2[$];

  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dutA (
    .clkIN(clk), .resetIN(reset), .dataIN(dataV[0][7:0]), .sendIN(sendV[0]),
    .txOUT(txV[0]), .readyOUT(readyV[0]), .busyOUT(busyV[0]),
    .overflowOUT(ovfV[0]), .fifoCountOUT(countA));

  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7),
                .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dutB (
    .clkIN(clk), .resetIN(reset), .dataIN(dataV[1][6:0]), .sendIN(sendV[1]),
    .txOUT(txV[1]), .readyOUT(readyV[1]), .busyOUT(busyV[1]),
    .overflowOUT(ovfV[1]), .fifoCountOUT(countB));

  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7),
                .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dutC (
    .clkIN(clk), .resetIN(reset), .dataIN(dataV[2][6:0]), .sendIN(sendV[2]),
    .txOUT(txV[2]), .readyOUT(readyV[2]), .busyOUT(busyV[2]),
    .overflowOUT(ovfV[2]), .fifoCountOUT(countC));

  always #5 clk = ~clk;

  function automatic int dataBitsOf(input int idx);
    return (idx == 0) ? 8 : 7;
  endfunction

  function automatic int parityOf(input int idx);
    return idx;
  endfunction

  function automatic int stopsOf(input int idx);
    return (idx == 0) ? 1 : 2;
  endfunction

  function automatic int frameLen(input int idx);
    return 1 + dataBitsOf(idx) + ((parityOf(idx) != 0) ? 1 : 0) + stopsOf(idx);
  endfunction

  function automatic logic [2:0] countOf(input int idx);
    case (idx)
      0:       return countA;
      1:       return countB;
      default: return countC;
    endcase
  endfunction

  // Reference frame: start 0, data LSB first, parity chosen so the total
  // number of ones is odd (mode 1) or even (mode 2), then stop ones.
  function automatic FrameT buildFrame(input int idx, input logic [8:0] d, input bit contig);
    FrameT f;
    int n;
    int ones;
    f.bits   = '0;
    f.contig = contig;
    n        = 1;
    ones     = 0;
    for (int i = 0; i < dataBitsOf(idx); i++) begin
      f.bits[n] = d[i];
      ones += int'(d[i]);
      n++;
    end
    if (parityOf(idx) == 1) begin
      f.bits[n] = (ones % 2 == 0);
      n++;
    end else if (parityOf(idx) == 2) begin
      f.bits[n] = (ones % 2 == 1);
      n++;
    end
    for (int s = 0; s < stopsOf(idx); s++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.len = n;
    return f;
  endfunction

  function automatic void pushExp(input int idx, input FrameT f);
    case (idx)
      0:       expQ0.push_back(f);
      1:       expQ1.push_back(f);
      default: expQ2.push_back(f);
    endcase
  endfunction

  function automatic void popExp(input int idx, output FrameT f, output bit ok);
    f.bits   = '0;
    f.len    = 0;
    f.contig = 1'b0;
    ok       = 1'b0;
    case (idx)
      0:       if (expQ0.size() > 0) begin f = expQ0.pop_front(); ok = 1'b1; end
      1:       if (expQ1.size() > 0) begin f = expQ1.pop_front(); ok = 1'b1; end
      default: if (expQ2.size() > 0) begin f = expQ2.pop_front(); ok = 1'b1; end
    endcase
  endfunction

  function automatic int queueSize(input int idx);
    case (idx)
      0:       return expQ0.size();
      1:       return expQ1.size();
      default: return expQ2.size();
    endcase
  endfunction

  // A reset discards everything queued or in flight.
  function automatic void flushAll();
    expQ0.delete();
    expQ1.delete();
    expQ2.delete();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  // Called just after an edge; the push lands on the next edge, and the
  // task returns 1ns after that edge with sendIN released.
  task automatic applyStimulus(input int idx, input logic [8:0] d, input bit contig, input bit accept);
    dataV[idx] = d;
    sendV[idx] = 1'b1;
    if (accept) begin
      pushExp(idx, buildFrame(idx, d, contig));
    end
    tick();
    sendV[idx] = 1'b0;
  endtask

  task automatic waitIdle(input int idx);
    int n;
    n = 0;
    while (busyV[idx] && n < 3000) begin
      tick();
      n++;
    end
    if (busyV[idx]) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitIdle dut%0d: busy still 1 after %0d cycles, required 0", idx, n);
    end
    repeat (4) tick();
  endtask

  // Line monitor: samples every falling edge, decodes one frame per start
  // bit, requires every bit to hold for DIV clocks and, for frames queued
  // behind another, no idle clock before the start bit.
  task automatic monitorLine(input int idx);
    FrameT expF;
    FrameT gotF;
    bit    haveExp;
    bit    stable;
    bit    aborted;
    int    idleRun;
    int    len;
    logic  v;
    idleRun = 0;
    len     = frameLen(idx);
    forever begin
      @(negedge clk);
      if (reset) begin
        idleRun = 0;
        continue;
      end
      if (txV[idx] !== 1'b0) begin
        idleRun++;
        continue;
      end
      popExp(idx, expF, haveExp);
      gotF.bits   = '0;
      gotF.len    = len;
      gotF.contig = (idleRun == 0);
      stable      = 1'b1;
      aborted     = 1'b0;
      for (int s = 0; s < len * DIV; s++) begin
        if (s > 0) @(negedge clk);
        if (reset) begin
          aborted = 1'b1;
          break;
        end
        v = txV[idx];
        if (s % DIV == 0) gotF.bits[s / DIV] = v;
        else if (v !== gotF.bits[s / DIV]) stable = 1'b0;
      end
      if (!aborted) begin
        checks++;
        if (!haveExp) begin
          errors++;
          $display("[TB] FAIL frame dut%0d: got unexpected frame %b, required none", idx, gotF.bits);
        end else if (gotF.bits !== expF.bits || !stable || (expF.contig && !gotF.contig)) begin
          errors++;
          $display("[TB] FAIL frame dut%0d: got bits %b stable %0d gapless %0d, required bits %b gapless %0d",
                   idx, gotF.bits, stable, gotF.contig, expF.bits, expF.contig);
        end
      end
      idleRun = 0;
    end
  endtask

  initial begin
    fork
      monitorLine(0);
      monitorLine(1);
      monitorLine(2);
    join_none
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [8:0] d;
    int         idx;
    int         n;

    for (int i = 0; i < 3; i++) dataV[i] = '0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state of all three transmitters.
    for (int i = 0; i < 3; i++) begin
      checkOutput("reset txOUT", txV[i], 1);
      checkOutput("reset readyOUT", readyV[i], 1);
      checkOutput("reset busyOUT", busyV[i], 0);
      checkOutput("reset overflowOUT", ovfV[i], 0);
      checkOutput("reset fifoCount", countOf(i), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();

    // 8N1 single character: latency and busy duration.
    applyStimulus(0, 9'h0A5, 1'b0, 1'b1);
    checkOutput("t1 count after push", countOf(0), 1);
    checkOutput("t1 line at push edge", txV[0], 1);
    tick();
    checkOutput("t1 line one after push", txV[0], 1);
    checkOutput("t1 busy", busyV[0], 1);
    tick();
    checkOutput("t1 start bit at k+2", txV[0], 0);
    repeat (98) tick();
    checkOutput("t1 busy before frame end", busyV[0], 1);
    tick();
    checkOutput("t1 busy after frame end", busyV[0], 0);
    waitIdle(0);

    // 7-bit, two stop bits, odd then even parity on 0x53.
    for (int p = 1; p <= 2; p++) begin
      applyStimulus(p, 9'h053, 1'b0, 1'b1);
      repeat (85) tick();
      checkOutput("t2 parity bit on line", txV[p], (p == 1) ? 1 : 0);
      repeat (25) tick();
      checkOutput("t2 busy at 110", busyV[p], 1);
      tick();
      checkOutput("t2 busy after 110", busyV[p], 0);
      waitIdle(p);
    end

    // Back-to-back characters pushed on consecutive edges.
    applyStimulus(0, 9'h000, 1'b0, 1'b1);
    checkOutput("t3 count after push 1", countOf(0), 1);
    applyStimulus(0, 9'h0FF, 1'b1, 1'b1);
    checkOutput("t3 count after push 2", countOf(0), 1);
    applyStimulus(0, 9'h00F, 1'b1, 1'b1);
    checkOutput("t3 count after push 3", countOf(0), 2);
    repeat (99) tick();
    checkOutput("t3 count after frame 2 start", countOf(0), 1);
    repeat (100) tick();
    checkOutput("t3 count after frame 3 start", countOf(0), 0);
    repeat (99) tick();
    checkOutput("t3 busy in last stop", busyV[0], 1);
    tick();
    checkOutput("t3 busy after last frame", busyV[0], 0);
    waitIdle(0);

    // Overflow: six consecutive pushes into a depth-4 FIFO.
    for (int i = 1; i <= 6; i++) begin
      checkOutput("t4 ready before push", readyV[0], (i <= 5) ? 1 : 0);
      applyStimulus(0, 9'(i), (i > 1), (i <= 5));
      checkOutput("t4 overflow after push", ovfV[0], (i == 6) ? 1 : 0);
    end
    checkOutput("t4 count when full", countOf(0), 4);
    tick();
    checkOutput("t4 overflow single pulse", ovfV[0], 0);
    waitIdle(0);

    // Simultaneous push and pop on the stop-to-start edge.
    applyStimulus(0, 9'h0C3, 1'b0, 1'b1);
    tick();
    applyStimulus(0, 9'h05A, 1'b1, 1'b1);
    checkOutput("t6 count one queued", countOf(0), 1);
    repeat (98) tick();
    checkOutput("t6 count before pop edge", countOf(0), 1);
    applyStimulus(0, 9'h0E7, 1'b1, 1'b1);
    checkOutput("t6 count after push+pop", countOf(0), 1);
    waitIdle(0);

    // Reset during data bit 3 with a second character queued.
    applyStimulus(0, 9'h03C, 1'b0, 1'b1);
    applyStimulus(0, 9'h055, 1'b1, 1'b1);
    checkOutput("t5 count before reset", countOf(0), 1);
    repeat (44) tick();
    #3;
    flushAll();
    reset = 1'b1;
    #1;
    checkOutput("t5 line after reset", txV[0], 1);
    checkOutput("t5 count after reset", countOf(0), 0);
    checkOutput("t5 busy after reset", busyV[0], 0);
    checkOutput("t5 ready after reset", readyV[0], 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    applyStimulus(0, 9'h081, 1'b0, 1'b1);
    waitIdle(0);

    // Reset during a start bit must lift the line at once.
    d = 9'($urandom_range(0, 255));
    applyStimulus(0, d, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("reset2 start bit low", txV[0], 0);
    #3;
    flushAll();
    reset = 1'b1;
    #1;
    checkOutput("reset2 line high async", txV[0], 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Random bursts of 1..4 characters on random transmitters.
    for (int r = 0; r < 8; r++) begin
      idx = $urandom_range(0, 2);
      n   = $urandom_range(1, 4);
      repeat ($urandom_range(0, 5)) tick();
      for (int j = 0; j < n; j++) begin
        d = 9'($urandom_range(0, (1 << dataBitsOf(idx)) - 1));
        applyStimulus(idx, d, (j > 0), 1'b1);
      end
      waitIdle(idx);
    end

    for (int i = 0; i < 3; i++) begin
      waitIdle(i);
      checkOutput("frames left unsent", 16'(queueSize(i)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
